// File: rtl/vga_sync_receiver.sv
// Sink-side VGA timing checker: measures incoming hSync/vSync, locks to the mode and regenerates counters/blanking.
// Optional mismatch event counter on errCnt is built when VGA_RX_ERR_CNT_EN is defined.
module vga_sync_receiver #(
    parameter int HDT         = 640,
    parameter int HFP         = 16,
    parameter int HSP         = 96,
    parameter int HBP         = 48,
    parameter int HPL         = 0,
    parameter int VDT         = 400,
    parameter int VFP         = 12,
    parameter int VSP         = 2,
    parameter int VBP         = 35,
    parameter int VPL         = 1,
    parameter int VSYNC_LINE  = 411,
    parameter int LOCK_FRAMES = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hSync,
    input  logic        vSync,
    output logic [9:0]  pixelCnt,
    output logic [8:0]  lineCnt,
    output logic        compBlank,
    output logic        locked,
    output logic        lockLost,
    output logic [10:0] hTotalMeas,
    output logic [9:0]  vTotalMeas,
    output logic [7:0]  errCnt
);
    localparam int   HTOTAL = HDT + HFP + HSP + HBP;
    localparam int   VTOTAL = VDT + VFP + VSP + VBP;
    localparam logic H_ACT  = (HPL != 0);
    localparam logic V_ACT  = (VPL != 0);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

    state_e      state_q, state_d;
    logic        h_s1_q, h_s2_q, h_prv_q, v_s1_q, v_s2_q, v_prv_q;
    logic        h_s1_d, h_s2_d, h_prv_d, v_s1_d, v_s2_d, v_prv_d;
    logic [9:0]  pix_q, pix_d;
    logic [8:0]  line_q, line_d;
    logic        blank_q, blank_d, locked_q, locked_d, lost_q, lost_d;
    logic [10:0] h_per_q, h_per_d, h_tot_q, h_tot_d, h_wid_q, h_wid_d;
    logic [9:0]  v_per_q, v_per_d, v_tot_q, v_tot_d, v_wid_q, v_wid_d;
    logic        h_wv_q, h_wv_d, v_wv_q, v_wv_d, h_arm_q, h_arm_d, v_arm_q, v_arm_d;
    logic [2:0]  good_q, good_d;
    logic        seen_q, seen_d;

    logic        h_rise, h_fall, v_rise, v_fall, pix_wrap, timeout, mismatch;
    logic [10:0] h_meas;
    logic [9:0]  v_per_inc;

    always_comb begin
        h_s1_d  = hSync;
        h_s2_d  = h_s1_q;
        h_prv_d = h_s2_q;
        v_s1_d  = vSync;
        v_s2_d  = v_s1_q;
        v_prv_d = v_s2_q;
        h_rise  = (h_s2_q == H_ACT) && (h_prv_q != H_ACT);
        h_fall  = (h_s2_q != H_ACT) && (h_prv_q == H_ACT);
        v_rise  = (v_s2_q == V_ACT) && (v_prv_q != V_ACT);
        v_fall  = (v_s2_q != V_ACT) && (v_prv_q == V_ACT);

        // Saturating period +1 doubles as the measured total at an hEdge.
        h_meas  = (h_per_q == 11'h7FF) ? h_per_q : h_per_q + 11'd1;
        h_per_d = h_rise ? 11'd0 : h_meas;
        h_tot_d = h_rise ? h_meas : h_tot_q;
        timeout = !h_rise && (h_per_q == 11'(2 * HTOTAL - 1));
        h_wid_d = h_wid_q;
        if (h_rise)
            h_wid_d = 11'd1;
        else if (h_s2_q == H_ACT && h_wid_q != 11'h7FF)
            h_wid_d = h_wid_q + 11'd1;
        h_wv_d  = h_rise ? 1'b1 : (h_fall ? 1'b0 : h_wv_q);

        v_per_inc = (v_per_q == 10'h3FF) ? v_per_q : v_per_q + {9'd0, h_rise};
        v_per_d   = v_rise ? {9'd0, h_rise} : v_per_inc;
        v_tot_d   = v_rise ? v_per_q : v_tot_q;
        v_wid_d   = v_wid_q;
        if (v_rise)
            v_wid_d = {9'd0, h_rise};
        else if (v_s2_q == V_ACT && h_rise && v_wid_q != 10'h3FF)
            v_wid_d = v_wid_q + 10'd1;
        v_wv_d    = v_rise ? 1'b1 : (v_fall ? 1'b0 : v_wv_q);

        mismatch = timeout
                 | (h_rise && h_arm_q && h_meas != 11'(HTOTAL))
                 | (h_fall && h_wv_q && h_wid_q != 11'(HSP))
                 | (v_rise && v_arm_q && v_per_q != 10'(VTOTAL))
                 | (v_fall && v_wv_q && v_wid_q != 10'(VSP));

        // An hEdge load beats the natural wrap, so no line advance on that clock.
        pix_wrap = !h_rise && (pix_q == 10'(HTOTAL - 1));
        pix_d    = h_rise ? 10'(HDT + HFP) : (pix_wrap ? 10'd0 : pix_q + 10'd1);
        line_d   = line_q;
        if (v_rise)
            line_d = 9'(VSYNC_LINE);
        else if (pix_wrap)
            line_d = (line_q == 9'(VTOTAL - 1)) ? 9'd0 : line_q + 9'd1;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            SEARCH: begin
                good_d = 3'd0;
                if (v_rise) state_d = MEASURE;
            end
            MEASURE: begin
                if (timeout) begin
                    state_d = SEARCH;
                    good_d  = 3'd0;
                end else if (v_rise) begin
                    if (seen_q || mismatch) begin
                        good_d = 3'd0;
                    end else begin
                        good_d = good_q + 3'd1;
                        if (good_d == 3'(LOCK_FRAMES)) state_d = LOCKED;
                    end
                end else if (mismatch) begin
                    good_d = 3'd0;
                end
            end
            LOCKED:  if (mismatch) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
        seen_d   = v_rise ? 1'b0 : (seen_q | mismatch);
        lost_d   = (state_q == LOCKED) && (state_d == SEARCH);
        locked_d = (state_d == LOCKED);
        // The first period seen after dropping back to SEARCH is not trusted.
        h_arm_d  = h_arm_q | h_rise;
        v_arm_d  = v_arm_q | v_rise;
        if (state_q != SEARCH && state_d == SEARCH) begin
            h_arm_d = 1'b0;
            v_arm_d = 1'b0;
        end
        blank_d  = !locked_d || (pix_d >= 10'(HDT)) || (line_d >= 9'(VDT));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= SEARCH;
            h_s1_q  <= ~H_ACT;
            h_s2_q  <= ~H_ACT;
            h_prv_q <= ~H_ACT;
            v_s1_q  <= ~V_ACT;
            v_s2_q  <= ~V_ACT;
            v_prv_q <= ~V_ACT;
            pix_q   <= '0;
            line_q  <= '0;
            blank_q <= 1'b1;
            locked_q <= 1'b0;
            lost_q  <= 1'b0;
            h_per_q <= '0;
            h_tot_q <= '0;
            h_wid_q <= '0;
            v_per_q <= '0;
            v_tot_q <= '0;
            v_wid_q <= '0;
            h_wv_q  <= 1'b0;
            v_wv_q  <= 1'b0;
            h_arm_q <= 1'b0;
            v_arm_q <= 1'b0;
            good_q  <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_s1_q  <= h_s1_d;
            h_s2_q  <= h_s2_d;
            h_prv_q <= h_prv_d;
            v_s1_q  <= v_s1_d;
            v_s2_q  <= v_s2_d;
            v_prv_q <= v_prv_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            blank_q <= blank_d;
            locked_q <= locked_d;
            lost_q  <= lost_d;
            h_per_q <= h_per_d;
            h_tot_q <= h_tot_d;
            h_wid_q <= h_wid_d;
            v_per_q <= v_per_d;
            v_tot_q <= v_tot_d;
            v_wid_q <= v_wid_d;
            h_wv_q  <= h_wv_d;
            v_wv_q  <= v_wv_d;
            h_arm_q <= h_arm_d;
            v_arm_q <= v_arm_d;
            good_q  <= good_d;
            seen_q  <= seen_d;
        end
    end

`ifdef VGA_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (mismatch && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign errCnt = err_cnt_q;
`else
    assign errCnt = 8'd0;
`endif

    assign pixelCnt   = pix_q;
    assign lineCnt    = line_q;
    assign compBlank  = blank_q;
    assign locked     = locked_q;
    assign lockLost   = lost_q;
    assign hTotalMeas = h_tot_q;
    assign vTotalMeas = v_tot_q;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a scaled-down mode: a timestamp-based model predicts every output each clock,
// plus directed checks for reset, lock timing, long line, bad width, timeout and mid-frame reset.
module tb_vga_sync_receiver;
  localparam int HDT = 16, HFP = 2, HSP = 4, HBP = 3, HPL = 0;
  localparam int VDT = 10, VFP = 2, VSP = 2, VBP = 3, VPL = 1;
  localparam int VSYNC_LINE = 11, LOCK_FRAMES = 3;
  localparam int HT = HDT + HFP + HSP + HBP;
  localparam int VT = VDT + VFP + VSP + VBP;
  localparam bit HA = (HPL != 0);
  localparam bit VA = (VPL != 0);
`ifdef VGA_RX_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clock = 1'b0, reset = 1'b0, hSync = 1'b1, vSync = 1'b0;
  logic [9:0]  pixelCnt;
  logic [8:0]  lineCnt;
  logic        compBlank, locked, lockLost;
  logic [10:0] hTotalMeas;
  logic [9:0]  vTotalMeas;
  logic [7:0]  errCnt;

  always #5 clock = ~clock;

  vga_sync_receiver #(
    .HDT(HDT), .HFP(HFP), .HSP(HSP), .HBP(HBP), .HPL(HPL),
    .VDT(VDT), .VFP(VFP), .VSP(VSP), .VBP(VBP), .VPL(VPL),
    .VSYNC_LINE(VSYNC_LINE), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clock(clock), .reset(reset), .hSync(hSync), .vSync(vSync),
    .pixelCnt(pixelCnt), .lineCnt(lineCnt), .compBlank(compBlank),
    .locked(locked), .lockLost(lockLost), .hTotalMeas(hTotalMeas),
    .vTotalMeas(vTotalMeas), .errCnt(errCnt)
  );

  int n_cmp = 0, n_bad = 0;
  int n_lost = 0, n_lock_cyc = 0, lost_htot = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // model: pin delay line, event timestamps, expected outputs
  int m_cyc = 0;
  bit hd [3];
  bit vd [3];
  bit f_hr, f_hf, f_vr, f_vf;
  int t_h, t_hr, hcount, hc_v, hc_vr;
  bit hw_v, vw_v, h_arm, v_arm, e_seen;
  int e_pix, e_line, e_htot, e_vtot, e_err, e_mode, e_good;
  bit e_locked, e_lost, e_blank;

  task automatic model_edge(input bit rst, input bit hp, input bit vp);
    int c, meas, vm, old_mode;
    bit mism, to, wrap;
    m_cyc++;
    c = m_cyc - 1;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin hd[i] = !HA; vd[i] = !VA; end
      f_hr = 0; f_hf = 0; f_vr = 0; f_vf = 0;
      t_h = m_cyc - 1; t_hr = 0; hcount = 0; hc_v = 0; hc_vr = 0;
      hw_v = 0; vw_v = 0; h_arm = 0; v_arm = 0; e_seen = 0;
      e_pix = 0; e_line = 0; e_htot = 0; e_vtot = 0; e_err = 0; e_mode = 0; e_good = 0;
      e_locked = 0; e_lost = 0; e_blank = 1;
      return;
    end
    mism = 0;
    to = !f_hr && (c - t_h == 2 * HT);
    if (f_hr) begin
      meas = (c - t_h > 2047) ? 2047 : c - t_h;
      if (h_arm && meas != HT) mism = 1;
      e_htot = meas; t_h = c;
    end
    if (f_hf && hw_v) begin
      if (c - t_hr != HSP) mism = 1;
      hw_v = 0;
    end
    if (f_hr) begin t_hr = c; hw_v = 1; end
    if (f_vr) begin
      vm = (hcount - hc_v > 1023) ? 1023 : hcount - hc_v;
      if (v_arm && vm != VT) mism = 1;
      e_vtot = vm; hc_v = hcount; hc_vr = hcount; vw_v = 1;
    end
    if (f_vf && vw_v) begin
      if (hcount - hc_vr != VSP) mism = 1;
      vw_v = 0;
    end
    if (to) mism = 1;
    if (f_hr) hcount++;
    wrap = !f_hr && e_pix == HT - 1;
    e_pix = f_hr ? HDT + HFP : (e_pix + 1) % HT;
    if (f_vr) e_line = VSYNC_LINE;
    else if (wrap) e_line = (e_line + 1) % VT;
    old_mode = e_mode;
    case (e_mode)
      0: begin e_good = 0; if (f_vr) e_mode = 1; end
      1: begin
        if (to) begin e_mode = 0; e_good = 0; end
        else if (f_vr) begin
          if (e_seen || mism) e_good = 0;
          else begin e_good++; if (e_good == LOCK_FRAMES) e_mode = 2; end
        end else if (mism) e_good = 0;
      end
      default: if (mism) e_mode = 0;
    endcase
    e_seen = f_vr ? 1'b0 : (e_seen || mism);
    if (old_mode != 0 && e_mode == 0) begin h_arm = 0; v_arm = 0; end
    else begin if (f_hr) h_arm = 1; if (f_vr) v_arm = 1; end
    e_locked = (e_mode == 2);
    e_lost = (old_mode == 2) && (e_mode == 0);
    if (ERR_EN && mism && e_err < 255) e_err++;
    e_blank = !e_locked || e_pix >= HDT || e_line >= VDT;
    hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = hp;
    vd[2] = vd[1]; vd[1] = vd[0]; vd[0] = vp;
    f_hr = (hd[1] == HA) && (hd[2] != HA);
    f_hf = (hd[1] != HA) && (hd[2] == HA);
    f_vr = (vd[1] == VA) && (vd[2] != VA);
    f_vf = (vd[1] != VA) && (vd[2] == VA);
  endtask

  task automatic step(input bit hp, input bit vp);
    hSync = hp;
    vSync = vp;
    @(posedge clock);
    #1;
    model_edge(reset, hp, vp);
    chk("pixelCnt", pixelCnt, e_pix);
    chk("lineCnt", lineCnt, e_line);
    chk("compBlank", compBlank, e_blank);
    chk("locked", locked, e_locked);
    chk("lockLost", lockLost, e_lost);
    chk("hTotalMeas", hTotalMeas, e_htot);
    chk("vTotalMeas", vTotalMeas, e_vtot);
    chk("errCnt", errCnt, e_err);
    if (lockLost) begin n_lost++; lost_htot = hTotalMeas; end
    if (locked) n_lock_cyc++;
  endtask

  // one frame: each line starts with the hSync pulse; vSync active for the first VSP lines
  task automatic run_frame(input int long_line, input int wid, input bit jit, input int rst_at);
    int k, len, w;
    k = 0;
    for (int l = 0; l < VT; l++) begin
      len = HT + ((l == long_line) ? 1 : 0);
      w = wid;
      if (jit && $urandom_range(15) == 0) begin
        if ($urandom_range(1) == 1) w = ($urandom_range(1) == 1) ? HSP + 1 : HSP - 1;
        else len = len + 1;
      end
      for (int p = 0; p < len; p++) begin
        if (k == rst_at) reset = 1'b0;
        step((p < w) ? HA : !HA, (l < VSP) ? VA : !VA);
        if (k == rst_at) begin
          reset = 1'b1;
          chk("rst_mid_locked", locked, 0);
          chk("rst_mid_pix", pixelCnt, 0);
          chk("rst_mid_line", lineCnt, 0);
          chk("rst_mid_lost", lockLost, 0);
          chk("rst_mid_blank", compBlank, 1);
        end
        k++;
      end
    end
  endtask

  task automatic relock(input string tag);
    for (int f = 0; f < 4; f++) begin
      run_frame(-1, HSP, 0, -1);
      chk(tag, locked, (f >= 3) ? 1 : 0);
    end
  endtask

  initial begin
    int base, gap;
    reset = 1'b0;
    repeat (5) step($urandom_range(1) == 1, $urandom_range(1) == 1);
    chk("rst_pix", pixelCnt, 0);
    chk("rst_line", lineCnt, 0);
    chk("rst_blank", compBlank, 1);
    chk("rst_locked", locked, 0);
    chk("rst_lost", lockLost, 0);
    chk("rst_htot", hTotalMeas, 0);
    chk("rst_vtot", vTotalMeas, 0);
    chk("rst_err", errCnt, 0);
    reset = 1'b1;

    for (int f = 0; f < 5; f++) begin
      run_frame(-1, HSP, 0, -1);
      chk("nom_lock", locked, (f >= 3) ? 1 : 0);
    end
    chk("nom_htot", hTotalMeas, HT);
    chk("nom_vtot", vTotalMeas, VT);

    base = n_lost;
    run_frame($urandom_range(VT - 3, 3), HSP, 0, -1);
    chk("long_lost_cnt", n_lost - base, 1);
    chk("long_htot", lost_htot, HT + 1);
    chk("long_locked", locked, 0);
    chk("long_err", errCnt, ERR_EN ? 1 : 0);
    relock("long_relock");

    run_frame(-1, HSP - 1, 0, -1);
    base = n_lock_cyc;
    repeat (17) run_frame(-1, HSP - 1, 0, -1);
    chk("badw_lock_cyc", n_lock_cyc - base, 0);
    chk("badw_err_sat", errCnt, ERR_EN ? 255 : 0);
    relock("badw_relock");

    base = n_lost;
    gap = 2 * HT + 10 + $urandom_range(20);
    repeat (gap) step(!HA, !VA);
    chk("to_lost_cnt", n_lost - base, 1);
    chk("to_locked", locked, 0);
    relock("to_relock");

    base = n_lost;
    run_frame(-1, HSP, 0, $urandom_range(HT * 12, HT * 3));
    chk("rst_mid_nolost", n_lost - base, 0);
    relock("rst_relock");

    repeat (8) run_frame(-1, HSP, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Sink-side counterpart of the VGA timing generator: consumes hSync/vSync from a 640x400@70 timing source.
- Measures line and frame timing and checks it against the expected mode.
- Once stable, regenerates pixel/line counters and composite blanking aligned to the incoming syncs.
- Used by downstream capture/overlay logic and for self-checking the timing generator on-chip.

Parameters:
- HDT, 640, horizontal display pixels
- HFP, 16, horizontal front porch
- HSP, 96, horizontal sync pulse width (clocks)
- HBP, 48, horizontal back porch; HTOTAL = HDT+HFP+HSP+HBP = 800
- HPL, 0, hSync active level
- VDT, 400, vertical display lines
- VFP, 12, vertical front porch
- VSP, 2, vertical sync width (lines)
- VBP, 35, vertical back porch; VTOTAL = 449
- VPL, 1, vSync active level
- VSYNC_LINE, 411, line number loaded into lineCnt on vSync active edge
- LOCK_FRAMES, 3, consecutive good frames required for lock (1..7)

Ports:
- clock  in  1  pixel clock
- reset  in  1  synchronous, active-low reset
- hSync  in  1  incoming horizontal sync, may be asynchronous
- vSync  in  1  incoming vertical sync, may be asynchronous
- pixelCnt  out  10  recovered pixel position
- lineCnt  out  9  recovered line position
- compBlank  out  1  recovered composite blanking; 1 = blank
- locked  out  1  timing verified and stable
- lockLost  out  1  one-clock pulse on LOCKED->SEARCH
- hTotalMeas  out  11  last measured clocks between hSync active edges
- vTotalMeas  out  10  last measured lines between vSync active edges
- errCnt  out  8  mismatch event counter (see optional feature)

Behaviour:
- Reset is synchronous and active-low: when reset==0 at a clock edge, all state clears.
- Reset values: pixelCnt 0, lineCnt 0, compBlank 1, locked 0, lockLost 0, hTotalMeas 0, vTotalMeas 0, errCnt 0, FSM SEARCH.
- Synchronizer registers reset to the inactive levels (~HPL, ~VPL).
- Input path: 2-flop synchronizer per sync, then an edge register.
- Active edge: synchronized signal at active level while the previous sample was inactive.
- Fixed latency of 3 clocks from input pin to edge flag.
- hEdge: next clock loads pixelCnt <= HDT+HFP, hTotalMeas <= hPer+1, and clears hPer.
  - Otherwise pixelCnt increments and wraps HTOTAL-1 -> 0.
  - hPer saturates at 2047.
- hSync width: clocks at active level after hEdge are counted into hWid; width is checked on the inactive edge.
- Line advance: lineCnt increments when pixelCnt wraps to 0, wrapping VTOTAL-1 -> 0.
- vEdge: lineCnt <= VSYNC_LINE, vTotalMeas <= vPer, and vPer clears.
  - vPer counts hEdges and saturates at 1023.
  - vSync width in lines (hEdges while active) is checked on the inactive edge.
- If hEdge and a pixel wrap occur in the same clock, the load wins. The same applies to vEdge versus a line increment.
- Mismatch event, flagged when any of the following is seen:
  - hTotalMeas != HTOTAL, evaluated at each hEdge except the first after SEARCH;
  - hWid != HSP;
  - vTotalMeas != VTOTAL, evaluated at each vEdge except the first after SEARCH;
  - vWid != VSP;
  - timeout: hPer reaches 2*HTOTAL with no hEdge.
- FSM:
  - SEARCH: wait for vEdge -> MEASURE; goodCnt = 0.
  - MEASURE: each vEdge with no mismatch since the previous vEdge increments goodCnt. When goodCnt reaches LOCK_FRAMES -> LOCKED. Any mismatch clears goodCnt and the FSM stays in MEASURE. Timeout -> SEARCH.
  - LOCKED: locked = 1. Any mismatch or timeout -> SEARCH; locked drops the following clock and lockLost pulses for that one clock.
- compBlank = 1 when not locked; otherwise 1 when pixelCnt >= HDT or lineCnt >= VDT. Registered, aligned with pixelCnt/lineCnt.
- Counters free-run in all states; only compBlank and locked are gated by lock state.

Optional Feature:
- Macro: VGA_RX_ERR_CNT_EN.
- Defined: errCnt increments by 1 per clock in which at least one mismatch is flagged. It saturates at 255 and clears only on reset.
- Undefined: errCnt is tied to 8'd0 and no counter logic is generated.

Test Plan:
- Reset held low 5 clocks with syncs toggling -> all outputs at reset values, FSM in SEARCH, compBlank = 1.
- Nominal 800x449 timing (HPL 0, VPL 1) for 5 frames -> hTotalMeas = 800, vTotalMeas = 449, locked rises at the 4th vEdge (1 + LOCK_FRAMES). pixelCnt = 656 three clocks after each hSync falling edge; compBlank = 0 only at pixelCnt<640 and lineCnt<400.
- After lock, one line of 801 clocks -> hTotalMeas = 801, lockLost single pulse, locked = 0, FSM in SEARCH, errCnt = 1 with macro defined (0 without). Relock after 4 further good vEdges.
- hSync pulse width 95 clocks in every line -> never locks, errCnt saturates at 255.
- hSync stuck inactive for 1600 clocks while locked -> timeout, lockLost pulse, locked = 0.
- Synchronous reset asserted mid-frame while locked -> next clock: locked = 0, pixelCnt = 0, lineCnt = 0, no lockLost pulse.
